// File: rtl/cr_prefix_fe_cmp_ctl_pkg.sv
// Shared types for the prefix front-end compare controller: compare encodings,
// controller states and the per-lane configuration record.
package cr_prefix_fe_cmp_ctl_pkg;

  typedef enum logic [1:0] {
    CMP_EQ   = 2'd0,
    CMP_LT   = 2'd1,
    CMP_GTEQ = 2'd2,
    CMP_NE   = 2'd3
  } prefix_compare_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } ctl_state_e;

  typedef struct packed {
    logic [7:0]           match_val;
    prefix_compare_type_e cmp_type;
  } cmp_cfg_t;

  localparam int CNT_W = 16;

  localparam cmp_cfg_t CFG_RST = '{match_val: 8'h00, cmp_type: CMP_EQ};

endpackage

// File: rtl/cr_prefix_fe_cmp_ctl_cfg_bank.sv
// Shadow/active lane configuration storage: shadow is written one lane at a time,
// active is loaded from shadow in a single cycle when swap is asserted.
module cr_prefix_fe_cmp_cfg_bank
  import cr_prefix_fe_cmp_ctl_pkg::*;
#(
  parameter int N_CMP = 8,
  parameter int IDX_W = $clog2(N_CMP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic [IDX_W-1:0]   idx,
  input  cmp_cfg_t           wr_cfg,
  input  logic               swap,
  output logic [N_CMP*8-1:0] match_val,
  output logic [N_CMP*2-1:0] cmp_type
);

  cmp_cfg_t shadow [N_CMP];
  cmp_cfg_t active [N_CMP];

  // Out-of-range indices match no lane and are dropped; non-blocking copy
  // means a write landing in the swap cycle stays in shadow only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CMP; i++) begin
        shadow[i] <= CFG_RST;
        active[i] <= CFG_RST;
      end
    end else begin
      for (int i = 0; i < N_CMP; i++) begin
        if (wr && (idx == IDX_W'(i))) shadow[i] <= wr_cfg;
        if (swap) active[i] <= shadow[i];
      end
    end
  end

  always_comb begin
    match_val = '0;
    cmp_type  = '0;
    for (int i = 0; i < N_CMP; i++) begin
      match_val[8*i +: 8] = active[i].match_val;
      cmp_type[2*i +: 2]  = active[i].cmp_type;
    end
  end

endmodule

// File: rtl/cr_prefix_fe_cmp_ctl.sv
// Prefix compare lane controller: streams characters to the lanes, gathers hits and
// swaps lane configuration only between frames. Optional per-lane hit counters
// are enabled by CR_PREFIX_FE_CMP_HIT_CNT_EN.
module cr_prefix_fe_cmp_ctl
  import cr_prefix_fe_cmp_ctl_pkg::*;
#(
  parameter int N_CMP = 8,
  parameter int IDX_W = $clog2(N_CMP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [7:0]         cfg_match_val,
  input  logic [1:0]         cfg_cmp_type,
  input  logic               cfg_commit,
  output logic               cfg_pend,
  input  logic [7:0]         in_char,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [7:0]         lane_char,
  output logic               lane_char_valid,
  output logic [N_CMP*8-1:0] lane_match_val,
  output logic [N_CMP*2-1:0] lane_cmp_type,
  input  logic [N_CMP-1:0]   lane_cmp_r,
  input  logic               lane_valid_r,
  output logic               res_valid,
  output logic [N_CMP-1:0]   res_hit,
`ifdef CR_PREFIX_FE_CMP_HIT_CNT_EN
  output logic               res_last,
  output logic [N_CMP*CNT_W-1:0] hit_cnt
`else
  output logic               res_last
`endif
);

  ctl_state_e state, state_nxt;
  logic       ready_st;
  logic       last_r;
  logic       swap;
  logic       commit_req;

  cmp_cfg_t wr_cfg;
  assign wr_cfg = '{match_val: cfg_match_val, cmp_type: prefix_compare_type_e'(cfg_cmp_type)};

  // A same-cycle commit counts as pending so the swap is not delayed a cycle.
  assign commit_req = cfg_pend | cfg_commit;
  assign swap       = (state == SWAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_st  = 1'b0;
    case (state)
      IDLE: begin
        if (commit_req) begin
          state_nxt = SWAP;
        end else begin
          ready_st = 1'b1;
          if (in_valid && !in_last) state_nxt = RUN;
        end
      end
      RUN: begin
        ready_st = 1'b1;
        if (in_valid && in_last) state_nxt = commit_req ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (lane_valid_r && last_r) state_nxt = SWAP;
      end
      SWAP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, not just after the first edge.
  assign in_ready        = ready_st & ~rst;
  assign lane_char       = in_char;
  assign lane_char_valid = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_pend <= 1'b0;
      last_r   <= 1'b0;
    end else begin
      if (swap)            cfg_pend <= 1'b0;
      else if (cfg_commit) cfg_pend <= 1'b1;
      last_r <= lane_char_valid & in_last;
    end
  end

  assign res_valid = lane_valid_r & ~rst;
  assign res_hit   = lane_cmp_r & {N_CMP{~rst}};
  assign res_last  = last_r;

  cr_prefix_fe_cmp_cfg_bank #(
    .N_CMP (N_CMP),
    .IDX_W (IDX_W)
  ) u_cfg_bank (
    .clk       (clk),
    .rst       (rst),
    .wr        (cfg_wr),
    .idx       (cfg_idx),
    .wr_cfg    (wr_cfg),
    .swap      (swap),
    .match_val (lane_match_val),
    .cmp_type  (lane_cmp_type)
  );

`ifdef CR_PREFIX_FE_CMP_HIT_CNT_EN
  logic [CNT_W-1:0] cnt [N_CMP];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CMP; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CMP; i++) begin
        if (swap)                                          cnt[i] <= '0;
        else if (res_valid && res_hit[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N_CMP; i++) hit_cnt[CNT_W*i +: CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_cr_prefix_fe_cmp_ctl.sv
// Directed bench for cr_prefix_fe_cmp_ctl with a behavioural 1-cycle lane bank.
// Built with six lanes so that an out-of-range cfg_idx is expressible.
module tb_cr_prefix_fe_cmp_ctl;
  import cr_prefix_fe_cmp_ctl_pkg::*;

  localparam int N  = 6;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_wr;
  logic [IW-1:0]  cfg_idx;
  logic [7:0]     cfg_match_val;
  logic [1:0]     cfg_cmp_type;
  logic           cfg_commit;
  logic           cfg_pend;
  logic [7:0]     in_char;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [7:0]     lane_char;
  logic           lane_char_valid;
  logic [N*8-1:0] lane_match_val;
  logic [N*2-1:0] lane_cmp_type;
  logic [N-1:0]   lane_cmp_r;
  logic           lane_valid_r;
  logic           res_valid;
  logic [N-1:0]   res_hit;
  logic           res_last;
`ifdef CR_PREFIX_FE_CMP_HIT_CNT_EN
  logic [N*CNT_W-1:0] hit_cnt;
`endif

  int n_cmp;
  int n_err;

  always #5 clk = ~clk;

  cr_prefix_fe_cmp_ctl #(.N_CMP(N), .IDX_W(IW)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_wr          (cfg_wr),
    .cfg_idx         (cfg_idx),
    .cfg_match_val   (cfg_match_val),
    .cfg_cmp_type    (cfg_cmp_type),
    .cfg_commit      (cfg_commit),
    .cfg_pend        (cfg_pend),
    .in_char         (in_char),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .lane_char       (lane_char),
    .lane_char_valid (lane_char_valid),
    .lane_match_val  (lane_match_val),
    .lane_cmp_type   (lane_cmp_type),
    .lane_cmp_r      (lane_cmp_r),
    .lane_valid_r    (lane_valid_r),
    .res_valid       (res_valid),
    .res_hit         (res_hit),
`ifdef CR_PREFIX_FE_CMP_HIT_CNT_EN
    .res_last        (res_last),
    .hit_cnt         (hit_cnt)
`else
    .res_last        (res_last)
`endif
  );

  function automatic logic lane_hit(input logic [7:0] c, input logic [7:0] m, input logic [1:0] t);
    case (t)
      2'd0:    return c == m;
      2'd1:    return c < m;
      2'd2:    return c >= m;
      default: return c != m;
    endcase
  endfunction

  // Stand-in for the external compare lanes: one register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cmp_r   <= '0;
      lane_valid_r <= 1'b0;
    end else begin
      lane_valid_r <= lane_char_valid;
      for (int i = 0; i < N; i++)
        lane_cmp_r[i] <= lane_char_valid && lane_hit(lane_char, lane_match_val[8*i +: 8], lane_cmp_type[2*i +: 2]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic wr, input logic [IW-1:0] idx, input logic [7:0] mv,
                         input logic [1:0] ty, input logic cm);
    cfg_wr        = wr;
    cfg_idx       = idx;
    cfg_match_val = mv;
    cfg_cmp_type  = ty;
    cfg_commit    = cm;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic l);
    in_valid = v;
    in_char  = c;
    in_last  = l;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b0);
    drive(1'b1, 8'h41, 1'b0);

    // reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready",   64'(in_ready), 64'd0);
    chk("rst_pend",       64'(cfg_pend), 64'd0);
    chk("rst_lane_valid", 64'(lane_char_valid), 64'd0);
    chk("rst_res_valid",  64'(res_valid), 64'd0);
    chk("rst_res_last",   64'(res_last), 64'd0);
    chk("rst_res_hit",    64'(res_hit), 64'd0);
    chk("rst_match_val",  64'(lane_match_val), 64'd0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    #1;
    chk("idle_ready",     64'(in_ready), 64'd1);
    chk("idle_match_val", 64'(lane_match_val), 64'd0);
    chk("idle_cmp_type",  64'(lane_cmp_type), 64'd0);

    // commit while idle
    @(negedge clk); set_cfg(1'b1, 3'd3, 8'h41, CMP_EQ, 1'b0);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b1); #1;
    chk("commit_idle_ready", 64'(in_ready), 64'd0);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b0); #1;
    chk("swap_ready",  64'(in_ready), 64'd0);
    chk("swap_pend",   64'(cfg_pend), 64'd1);
    chk("swap_lane3_old", 64'(lane_match_val[31:24]), 64'h00);
    @(negedge clk); #1;
    chk("lane3_new",   64'(lane_match_val[31:24]), 64'h41);
    chk("pend_clear",  64'(cfg_pend), 64'd0);
    chk("ready_back",  64'(in_ready), 64'd1);

    // compare latency, write and commit in the same cycle
    @(negedge clk); set_cfg(1'b1, 3'd2, 8'h30, CMP_LT, 1'b1);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b0);
    @(negedge clk); drive(1'b1, 8'h20, 1'b1); #1;
    chk("lane2_wr_commit", 64'(lane_match_val[23:16]), 64'h30);
    chk("lat_accept",   64'(lane_char_valid), 64'd1);
    chk("lat_char",     64'(lane_char), 64'h20);
    chk("lat_res_t0",   64'(res_valid), 64'd0);
    @(negedge clk); drive(1'b0, 8'h00, 1'b0); #1;
    chk("lat_res_valid", 64'(res_valid), 64'd1);
    chk("lat_res_hit",   64'(res_hit), 64'b000100);
    chk("lat_res_last",  64'(res_last), 64'd1);
    @(negedge clk); #1;
    chk("lat_res_gone",  64'(res_valid), 64'd0);

    // commit mid-frame "ABC"
    @(negedge clk); drive(1'b1, 8'h41, 1'b0); #1;
    chk("abc_ready_a", 64'(in_ready), 64'd1);
    @(negedge clk); drive(1'b1, 8'h42, 1'b0); set_cfg(1'b1, 3'd0, 8'h42, CMP_GTEQ, 1'b1); #1;
    chk("abc_hit_a",  64'(res_hit), 64'b001000);
    chk("abc_last_a", 64'(res_last), 64'd0);
    @(negedge clk); drive(1'b1, 8'h43, 1'b1); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b0); #1;
    chk("abc_pend",    64'(cfg_pend), 64'd1);
    chk("abc_ready_c", 64'(in_ready), 64'd1);
    chk("abc_hit_b",   64'(res_hit), 64'b000000);
    @(negedge clk); drive(1'b1, 8'h41, 1'b1); #1;
    chk("drain_ready",  64'(in_ready), 64'd0);
    chk("drain_lane_v", 64'(lane_char_valid), 64'd0);
    chk("abc_valid_c",  64'(res_valid), 64'd1);
    chk("abc_hit_c",    64'(res_hit), 64'b000000);
    chk("abc_last_c",   64'(res_last), 64'd1);
    @(negedge clk); #1;
    chk("mid_swap_ready", 64'(in_ready), 64'd0);
    chk("mid_swap_old",   64'(lane_match_val[7:0]), 64'h00);
    @(negedge clk); #1;
    chk("mid_ready_back", 64'(in_ready), 64'd1);
    chk("lane0_new_val",  64'(lane_match_val[7:0]), 64'h42);
    chk("lane0_new_type", 64'(lane_cmp_type[1:0]), 64'(CMP_GTEQ));
    chk("mid_pend_clear", 64'(cfg_pend), 64'd0);
    @(negedge clk); drive(1'b1, 8'h43, 1'b1); #1;
    chk("new_hit_a",  64'(res_hit), 64'b001000);
    @(negedge clk); drive(1'b0, 8'h00, 1'b0); #1;
    chk("new_hit_c",  64'(res_hit), 64'b000001);

    // double commit, write+commit in the same cycle
    @(negedge clk); set_cfg(1'b1, 3'd1, 8'h55, CMP_NE, 1'b1); #1;
    chk("dbl_ready0", 64'(in_ready), 64'd0);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b1); #1;
    chk("dbl_swap",   64'(in_ready), 64'd0);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b0); #1;
    chk("dbl_pend",   64'(cfg_pend), 64'd0);
    chk("dbl_ready1", 64'(in_ready), 64'd1);
    chk("dbl_lane1",  64'(lane_match_val[15:8]), 64'h55);
    @(negedge clk); #1;
    chk("dbl_ready2", 64'(in_ready), 64'd1);

    // out-of-range lane index
    @(negedge clk); set_cfg(1'b1, 3'd6, 8'hAA, CMP_LT, 1'b0);
    @(negedge clk); set_cfg(1'b1, 3'd7, 8'hBB, CMP_LT, 1'b1);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b0);
    @(negedge clk); #1;
    chk("oob_match_val", 64'(lane_match_val), 64'h0000_4130_5542);
    chk("oob_cmp_type",  64'(lane_cmp_type), 64'h01E);

    // write during swap stays in shadow
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b1);
    @(negedge clk); set_cfg(1'b1, 3'd4, 8'h77, CMP_EQ, 1'b0);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b0); #1;
    chk("swapwr_active", 64'(lane_match_val[39:32]), 64'h00);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b1);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b0);
    @(negedge clk); #1;
    chk("swapwr_later", 64'(lane_match_val[39:32]), 64'h77);

    // reset mid-frame
    @(negedge clk); drive(1'b1, 8'h41, 1'b0);
    @(negedge clk); drive(1'b1, 8'h42, 1'b0); set_cfg(1'b1, 3'd5, 8'h99, CMP_EQ, 1'b1);
    @(negedge clk); drive(1'b0, 8'h00, 1'b0); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b0); #1;
    chk("rmf_pend", 64'(cfg_pend), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmf_match_val", 64'(lane_match_val), 64'd0);
    chk("rmf_pend_lost", 64'(cfg_pend), 64'd0);
    chk("rmf_ready",     64'(in_ready), 64'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rmf_idle_ready", 64'(in_ready), 64'd1);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b1);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b0);
    @(negedge clk); #1;
    chk("rmf_shadow_clr", 64'(lane_match_val), 64'd0);

`ifdef CR_PREFIX_FE_CMP_HIT_CNT_EN
    // saturating hit counter, cleared by swap
    @(negedge clk); drive(1'b1, 8'h00, 1'b0);
    repeat (70000) @(negedge clk);
    drive(1'b1, 8'h00, 1'b1);
    @(negedge clk); drive(1'b0, 8'h00, 1'b0);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b1); #1;
    chk("cnt_sat", 64'(hit_cnt[15:0]), 64'hFFFF);
    @(negedge clk); set_cfg(1'b0, '0, 8'h00, CMP_EQ, 1'b0);
    @(negedge clk); #1;
    chk("cnt_clr", 64'(hit_cnt[15:0]), 64'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
